// File: rtl/cv32e40p_irq_nest_sched_if.sv
// rtl/cv32e40p_irq_nest_sched_if.sv - request/ack and mret handshake between scheduler and controller
interface cv32e40p_irq_nest_sched_if #(
  parameter int NUM_IRQ = 32,
  parameter int LVL_W   = 3
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic            irq_req_o;
  logic [ID_W-1:0] irq_id_o;
  logic [LVL_W-1:0] irq_lvl_o;
  logic            irq_ack_i;
  logic            mret_i;

  modport master (
    output irq_req_o, irq_id_o, irq_lvl_o,
    input  irq_ack_i, mret_i
  );

  modport slave (
    input  irq_req_o, irq_id_o, irq_lvl_o,
    output irq_ack_i, mret_i
  );
endinterface

// File: rtl/cv32e40p_irq_nest_sched.sv
// rtl/cv32e40p_irq_nest_sched.sv - interrupt priority arbiter with a nesting stack of active levels
module cv32e40p_irq_nest_sched #(
  parameter int NUM_IRQ    = 32,
  parameter int LVL_W      = 3,
  parameter int NEST_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_IRQ-1:0]                irq_i,
  input  logic [NUM_IRQ-1:0]                irq_edge_i,
  input  logic [NUM_IRQ-1:0]                irq_en_i,
  input  logic [NUM_IRQ*LVL_W-1:0]          irq_lvl_i,
  input  logic                              m_ie_i,
  cv32e40p_irq_nest_sched_if.master         ctrl,
  output logic [NUM_IRQ-1:0]                pend_o,
  output logic [LVL_W-1:0]                  act_lvl_o,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_depth_o
);
  localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
  localparam int SIDX_W  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(NEST_DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ID_W-1:0]   id_q;
  logic [LVL_W-1:0]  lvl_q;

  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] ack_clr;

  logic [LVL_W-1:0]   stack_q [NEST_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [LVL_W-1:0]   act_lvl;
  logic [SIDX_W-1:0]  top_idx;
  logic [SIDX_W-1:0]  push_idx;

  logic              not_full;
  logic              ack_take;
  logic              pop_ok;
  logic              frozen_elig;
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  logic [LVL_W-1:0]  win_lvl;

  assign top_idx  = SIDX_W'(depth_q - DEPTH_W'(1));
  assign push_idx = SIDX_W'(depth_q);
  assign act_lvl  = (depth_q == '0) ? '0 : stack_q[top_idx];
  assign not_full = (depth_q < FULL);
  assign ack_take = (state_q == REQ) && ctrl.irq_ack_i;
  assign pop_ok   = ctrl.mret_i && (depth_q != '0);

  always_comb begin
    elig    = '0;
    ack_clr = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      elig[n] = pend_q[n] & irq_en_i[n] & m_ie_i & not_full &
                (irq_lvl_i[n*LVL_W +: LVL_W] > act_lvl);
    end
    if (ack_take) begin
      ack_clr[id_q] = 1'b1;
    end
  end

  // Ascending scan with >= lets the higher ID win a level tie.
  always_comb begin
    win_vld = |elig;
    win_id  = '0;
    win_lvl = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      if (elig[n] && (irq_lvl_i[n*LVL_W +: LVL_W] >= win_lvl)) begin
        win_id  = ID_W'(n);
        win_lvl = irq_lvl_i[n*LVL_W +: LVL_W];
      end
    end
  end

  assign frozen_elig = elig[id_q];

  // Edge lines: a fresh rising edge overrides a same-cycle ack clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      irq_q  <= '0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= (irq_i & ~irq_edge_i) |
                (irq_edge_i & ((irq_i & ~irq_q) | (pend_q & ~ack_clr)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
      lvl_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            id_q    <= win_id;
            lvl_q   <= win_lvl;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ctrl.irq_ack_i || !frozen_elig) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A request is only raised below full, so a push can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (ack_take && pop_ok) begin
      stack_q[top_idx] <= lvl_q;
    end else if (ack_take) begin
      stack_q[push_idx] <= lvl_q;
      depth_q           <= depth_q + DEPTH_W'(1);
    end else if (pop_ok) begin
      depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  assign ctrl.irq_req_o = req_q;
  assign ctrl.irq_id_o  = id_q;
  assign ctrl.irq_lvl_o = lvl_q;
  assign pend_o         = pend_q;
  assign act_lvl_o      = act_lvl;
  assign nest_depth_o   = depth_q;
endmodule
